// File: rtl/matrix_stream_pkg.sv
// Shared types and default sizing for the streaming matrix multiplier.
package matrix_stream_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned MAX_SIZE_DEF = 10;
  localparam int unsigned IDX_W        = $clog2(MAX_SIZE_DEF);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    MAC,
    EMIT
  } state_t;

endpackage

// File: rtl/matrix_mac_unit.sv
// Single multiply-accumulate lane; product and sum wrap modulo 2^DATA_W.
module matrix_mac_unit
  import matrix_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  output logic [DATA_W-1:0] acc_o
);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (enable_i) begin
      acc_d = acc_q + (op_a_i * op_b_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/matrix_mult_stream.sv
// Streaming C = A x B: buffers A and B from a valid/ready input, computes each
// C element with one MAC lane, and emits C row-major on a valid/ready output.
module matrix_mult_stream
  import matrix_stream_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_SIZE = MAX_SIZE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       matrix_size,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Row/column indices; N itself and the MAC step counter need one more bit.
  localparam int unsigned IW    = (MAX_SIZE <= MAX_SIZE_DEF) ? IDX_W : $clog2(MAX_SIZE);
  localparam int unsigned NW    = IW + 1;
  localparam int unsigned AW    = 2 * IW;
  localparam int unsigned DEPTH = MAX_SIZE * MAX_SIZE;

  state_t          state_q, state_d;
  logic [NW-1:0]   n_q, n_d;
  logic [IW-1:0]   row_q, row_d, col_q, col_d;
  logic [IW-1:0]   i_q, i_d, j_q, j_d;
  logic [NW-1:0]   k_q, k_d;
  logic            done_q, done_d, err_q, err_d;

  logic [DATA_W-1:0] a_mem [DEPTH];
  logic [DATA_W-1:0] b_mem [DEPTH];

  logic              size_ok, in_fire, out_fire;
  logic [IW-1:0]     nm1, k_idx;
  logic              col_last, row_last, load_last, emit_last;
  logic              mac_clear, mac_en;
  logic [AW-1:0]     wr_addr, a_addr, b_addr;
  logic [DATA_W-1:0] acc;

  assign size_ok   = (matrix_size != 32'd0) && (matrix_size <= MAX_SIZE);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign nm1       = IW'(n_q - NW'(1));
  assign col_last  = (col_q == nm1);
  assign row_last  = (row_q == nm1);
  assign load_last = in_fire && col_last && row_last;
  assign emit_last = (i_q == nm1) && (j_q == nm1);

  // The first MAC cycle (k_q == 0) clears the accumulator; k_q = 1..N add term k_q-1.
  assign mac_clear = (state_q == MAC) && (k_q == '0);
  assign mac_en    = (state_q == MAC) && (k_q != '0);
  assign k_idx     = (k_q == '0) ? '0 : IW'(k_q - NW'(1));

  assign wr_addr = AW'(row_q) * AW'(MAX_SIZE) + AW'(col_q);
  assign a_addr  = AW'(i_q) * AW'(MAX_SIZE) + AW'(k_idx);
  assign b_addr  = AW'(k_idx) * AW'(MAX_SIZE) + AW'(j_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && size_ok) state_d = LOAD_A;
      LOAD_A:  if (load_last) state_d = LOAD_B;
      LOAD_B:  if (load_last) state_d = MAC;
      MAC:     if (k_q == n_q) state_d = EMIT;
      EMIT:    if (out_fire) state_d = emit_last ? IDLE : MAC;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
    out_valid = (state_q == EMIT);
    out_last  = (state_q == EMIT) && emit_last;
    out_data  = (state_q == EMIT) ? acc : '0;
    busy      = (state_q != IDLE);
    done      = done_q;
    err       = err_q;
  end

  always_comb begin
    n_d    = n_q;
    row_d  = row_q;
    col_d  = col_q;
    i_d    = i_q;
    j_d    = j_q;
    k_d    = k_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (size_ok) begin
            n_d   = NW'(matrix_size);
            row_d = '0;
            col_d = '0;
            i_d   = '0;
            j_d   = '0;
            k_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD_A, LOAD_B: begin
        // Counters wrap back to zero after A so B loads from (0,0).
        if (in_fire) begin
          if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + IW'(1);
          end else begin
            col_d = col_q + IW'(1);
          end
        end
      end
      MAC: begin
        k_d = k_q + NW'(1);
      end
      EMIT: begin
        if (out_fire) begin
          k_d = '0;
          if (j_q == nm1) begin
            j_d = '0;
            i_d = emit_last ? '0 : i_q + IW'(1);
          end else begin
            j_d = j_q + IW'(1);
          end
          done_d = emit_last;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q    <= '0;
      row_q  <= '0;
      col_q  <= '0;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      n_q    <= n_d;
      row_q  <= row_d;
      col_q  <= col_d;
      i_q    <= i_d;
      j_q    <= j_d;
      k_q    <= k_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  // Operand storage carries no reset; stale contents are never read before reload.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      if (state_q == LOAD_A) begin
        a_mem[wr_addr] <= in_data;
      end else begin
        b_mem[wr_addr] <= in_data;
      end
    end
  end

  matrix_mac_unit #(
    .DATA_W(DATA_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (mac_clear),
    .enable_i (mac_en),
    .op_a_i   (a_mem[a_addr]),
    .op_b_i   (b_mem[b_addr]),
    .acc_o    (acc)
  );

endmodule

// File: tb/tb_matrix_mult_stream.sv
// Directed bench for matrix_mult_stream with hand-computed expected C streams.
module tb_matrix_mult_stream;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] matrix_size;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int last_hs_cyc = 0;

  logic [31:0] s_v [200];
  logic [31:0] obs [100];
  logic [31:0] exp_q [$];

  matrix_mult_stream dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .matrix_size (matrix_size),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int n);
    start       = 1'b1;
    matrix_size = n;
    tick();
    start       = 1'b0;
    matrix_size = 32'd7;
  endtask

  task automatic send(input int count);
    int budget;
    for (int idx = 0; idx < count; idx++) begin
      in_valid = 1'b1;
      in_data  = s_v[idx];
      budget   = 0;
      while (!in_ready && budget < 200) begin
        tick();
        budget++;
      end
      if (!in_ready) begin
        check_eq("in_ready_wait", {31'b0, in_ready}, 32'd1);
        break;
      end
      tick();
      last_hs_cyc = cyc;
    end
    in_valid = 1'b0;
    in_data  = 32'h0;
  endtask

  // Scoreboard: every handshaken element is compared with the head of exp_q.
  task automatic collect(input int n, input int stall_idx, output int first_lat);
    int got;
    int budget;
    bit first;
    logic [31:0] want;
    got       = 0;
    budget    = 0;
    first     = 1'b1;
    first_lat = -1;
    out_ready = 1'b1;
    while (got < n * n && budget < 5000) begin
      if (out_valid) begin
        if (first) begin
          first_lat = cyc - last_hs_cyc;
          first     = 1'b0;
        end
        if (got == stall_idx) begin
          out_ready = 1'b0;
          for (int s = 0; s < 5; s++) begin
            tick();
            check_eq("stall_valid", {31'b0, out_valid}, 32'd1);
            check_eq("stall_data", out_data, exp_q[0]);
          end
          out_ready = 1'b1;
        end
        want = exp_q.pop_front();
        check_eq("out_data", out_data, want);
        check_eq("out_last", {31'b0, out_last}, {31'b0, (got == n * n - 1)});
        obs[got] = out_data;
        got++;
      end
      tick();
      budget++;
    end
    check_eq("out_count", got, n * n);
    check_eq("done_pulse", {31'b0, done}, 32'd1);
    check_eq("busy_after", {31'b0, busy}, 32'd0);
    check_eq("valid_after", {31'b0, out_valid}, 32'd0);
    tick();
    check_eq("done_clear", {31'b0, done}, 32'd0);
  endtask

  task automatic model_push(input int n);
    logic [31:0] acc;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        acc = 32'h0;
        for (int k = 0; k < n; k++) begin
          acc = acc + s_v[i * n + k] * s_v[n * n + k * n + j];
        end
        exp_q.push_back(acc);
      end
    end
  endtask

  task automatic load_2x2(input logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3);
    s_v[0] = a0; s_v[1] = a1; s_v[2] = a2; s_v[3] = a3;
    s_v[4] = b0; s_v[5] = b1; s_v[6] = b2; s_v[7] = b3;
  endtask

  initial begin
    int lat;
    rst_n       = 1'b0;
    start       = 1'b0;
    matrix_size = 32'd0;
    in_valid    = 1'b0;
    in_data     = 32'h0;
    out_ready   = 1'b0;
    repeat (3) tick();
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done_err", {30'b0, done, err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // N=2, identity B; a second start mid-job must be ignored
    load_2x2(1, 2, 3, 4, 1, 0, 0, 1);
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4);
    start_job(2);
    start = 1'b1; matrix_size = 32'd3;
    tick();
    start = 1'b0;
    check_eq("busy_start_ignored", {31'b0, busy}, 32'd1);
    check_eq("in_ready_load", {31'b0, in_ready}, 32'd1);
    send(8);
    collect(2, -1, lat);
    check_eq("lat_n2", lat, 32'd3);

    // N=10 with A[i][j]=10i+j+1, B[i][j]=100-10j-i
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 10; j++) begin
        s_v[i * 10 + j]       = 10 * i + j + 1;
        s_v[100 + i * 10 + j] = 100 - 10 * j - i;
      end
    end
    model_push(10);
    start_job(10);
    send(200);
    collect(10, -1, lat);
    check_eq("lat_n10", lat, 32'd11);
    check_eq("c00_n10", obs[0], 32'd5170);
    check_eq("c09_n10", obs[9], 32'd220);

    // N=1 truncation; in_valid left high outside the load phase
    s_v[0] = 32'hFFFF_FFFF;
    s_v[1] = 32'd2;
    exp_q.push_back(32'hFFFF_FFFE);
    start_job(1);
    send(2);
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    check_eq("in_ready_mac", {31'b0, in_ready}, 32'd0);
    collect(1, -1, lat);
    in_valid = 1'b0;
    check_eq("lat_n1", lat, 32'd2);

    // Backpressure on the second element
    load_2x2(2, 3, 4, 5, 6, 7, 8, 9);
    exp_q.push_back(36); exp_q.push_back(41); exp_q.push_back(64); exp_q.push_back(73);
    start_job(2);
    send(8);
    collect(2, 1, lat);

    // Illegal sizes, with in_valid asserted to show it is ignored
    in_valid = 1'b1;
    start_job(0);
    check_eq("err_size0", {31'b0, err}, 32'd1);
    check_eq("busy_size0", {31'b0, busy}, 32'd0);
    check_eq("in_ready_size0", {31'b0, in_ready}, 32'd0);
    tick();
    check_eq("err_clear0", {31'b0, err}, 32'd0);
    start_job(11);
    check_eq("err_size11", {31'b0, err}, 32'd1);
    check_eq("busy_size11", {31'b0, busy}, 32'd0);
    check_eq("in_ready_size11", {31'b0, in_ready}, 32'd0);
    tick();
    check_eq("err_clear11", {31'b0, err}, 32'd0);
    in_valid = 1'b0;

    // Reset after three B handshakes, then a clean job
    load_2x2(9, 9, 9, 9, 9, 9, 9, 9);
    start_job(2);
    send(7);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", {31'b0, busy}, 32'd0);
    check_eq("abort_in_ready", {31'b0, in_ready}, 32'd0);
    check_eq("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("abort_out_data", out_data, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    load_2x2(5, 6, 7, 8, 1, 2, 3, 4);
    exp_q.push_back(23); exp_q.push_back(34); exp_q.push_back(31); exp_q.push_back(46);
    start_job(2);
    send(8);
    collect(2, -1, lat);
    check_eq("exp_q_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fails);
    $finish;
  end

endmodule
